// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared definitions for the MAC datapath: default operand
//               sizing and the joined {a, b} request-message layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Default operand width and per-stream queue depth
    localparam int c_mac_width = 8;
    localparam int c_mac_depth = 2;

    // Joined request message: A occupies the upper half, B the lower half
    typedef struct packed {
        logic [c_mac_width-1:0] a;
        logic [c_mac_width-1:0] b;
    } mac_pair_t;

    // Builds a joined message from two default-width operands
    function automatic mac_pair_t mac_join(input logic [c_mac_width-1:0] a,
                                           input logic [c_mac_width-1:0] b);
        mac_pair_t pair;
        pair.a = a;
        pair.b = b;
        return pair;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_operand_queue.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_queue
// Description : Circular FIFO of p_depth operands with val/rdy on both sides.
//               enq_rdy is a pure register output so the upstream ready path
//               never depends combinationally on the dequeue side.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_queue
    import mac_pkg::*;
#(
    parameter int p_width = c_mac_width,
    parameter int p_depth = c_mac_depth
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_msg
);

    localparam int c_ptr_w = $clog2(p_depth);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(p_depth);

    logic [p_width-1:0] r_storage [p_depth];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_enq_rdy;

    logic               w_not_empty;
    logic               w_enq;
    logic               w_deq;
    logic [c_cnt_w-1:0] w_count_next;

    assign w_not_empty = (r_count != c_cnt_zero);
    // Enqueue is gated by the registered ready, so a full queue never
    // accepts even when a dequeue happens in the same cycle.
    assign w_enq       = enq_val && r_enq_rdy;
    assign w_deq       = deq_rdy && w_not_empty;

    // Occupancy after this cycle's enqueue/dequeue
    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer, occupancy and registered-ready update; pointers wrap
    // naturally because p_depth is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_enq_rdy <= 1'b1;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_deq) begin
                r_head <= r_head + c_ptr_one;
            end
            r_count   <= w_count_next;
            r_enq_rdy <= (w_count_next != c_cnt_full);
        end
    end

    // Operand storage write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_storage[r_tail] <= enq_msg;
        end
    end

    assign enq_rdy = r_enq_rdy;
    assign deq_val = w_not_empty;
    assign deq_msg = r_storage[r_head];

endmodule
`default_nettype wire

// File: rtl/mac_operand_join.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_join
// Description : Pairs operand streams A and B in arrival order and presents
//               each pair as a registered {a, b} message to the MAC stage.
//               One pair per cycle; out_rdy never reaches a_rdy/b_rdy
//               combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_join
    import mac_pkg::*;
#(
    parameter int p_width = c_mac_width,
    parameter int p_depth = c_mac_depth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_val,
    output logic                 a_rdy,
    input  logic [p_width-1:0]   a_msg,
    input  logic                 b_val,
    output logic                 b_rdy,
    input  logic [p_width-1:0]   b_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [2*p_width-1:0] out_msg
);

    // Same half ordering as mac_pair_t, sized by this instance's width
    typedef struct packed {
        logic [p_width-1:0] a;
        logic [p_width-1:0] b;
    } pair_t;

    logic               w_a_head_val;
    logic [p_width-1:0] w_a_head_msg;
    logic               w_b_head_val;
    logic [p_width-1:0] w_b_head_msg;
    logic               w_load;
    pair_t              w_pair;

    logic               r_out_val;
    pair_t              r_out_msg;

    mac_operand_queue #(
        .p_width (p_width),
        .p_depth (p_depth)
    ) u_queue_a (
        .clk     (clk),
        .reset   (reset),
        .enq_val (a_val),
        .enq_rdy (a_rdy),
        .enq_msg (a_msg),
        .deq_val (w_a_head_val),
        .deq_rdy (w_load),
        .deq_msg (w_a_head_msg)
    );

    mac_operand_queue #(
        .p_width (p_width),
        .p_depth (p_depth)
    ) u_queue_b (
        .clk     (clk),
        .reset   (reset),
        .enq_val (b_val),
        .enq_rdy (b_rdy),
        .enq_msg (b_msg),
        .deq_val (w_b_head_val),
        .deq_rdy (w_load),
        .deq_msg (w_b_head_msg)
    );

    // Both heads present and the output slot is free or draining this cycle;
    // both queues pop together so pairing stays strictly positional.
    assign w_load = w_a_head_val && w_b_head_val && (!r_out_val || out_rdy);

    assign w_pair.a = w_a_head_msg;
    assign w_pair.b = w_b_head_msg;

    // Output register: load a new pair, clear on drain, otherwise hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_val <= 1'b0;
            r_out_msg <= '0;
        end else if (w_load) begin
            r_out_val <= 1'b1;
            r_out_msg <= w_pair;
        end else if (r_out_val && out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign out_val = r_out_val;
    assign out_msg = r_out_msg;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_join.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_operand_join
// Description : Self-checking bench for mac_operand_join (p_width=8,
//               p_depth=2): directed scenarios plus a randomized run checked
//               against a positional-pairing scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_operand_join;

    logic        clk;
    logic        reset;
    logic        a_val;
    logic        a_rdy;
    logic [7:0]  a_msg;
    logic        b_val;
    logic        b_rdy;
    logic [7:0]  b_msg;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out_msg;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: accepted operands per stream and transferred outputs
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] q_got[$];

    mac_operand_join #(
        .p_width (8),
        .p_depth (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a_val   (a_val),
        .a_rdy   (a_rdy),
        .a_msg   (a_msg),
        .b_val   (b_val),
        .b_rdy   (b_rdy),
        .b_msg   (b_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record handshakes at the falling edge; inputs are stable here and
    // match what the next rising edge will sample
    always @(negedge clk) begin
        if (reset) begin
            if (a_val && a_rdy)     qa.push_back(a_msg);
            if (b_val && b_rdy)     qb.push_back(b_msg);
            if (out_val && out_rdy) q_got.push_back(out_msg);
        end
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_val = 1'b0; a_msg = '0;
        b_val = 1'b0; b_msg = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        out_rdy = 1'b0;
        step();
        step();
        reset = 1'b1;
        qa.delete(); qb.delete(); q_got.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        out_rdy = 1'b1;
        step();
        step();
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL reset_out_val: got %b want 0", out_val);
        else n_pass++;
        n_checks++;
        if (out_msg !== 16'h0000) $display("FAIL reset_out_msg: got %h want 0000", out_msg);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1)
            $display("FAIL reset_rdy: got a=%b b=%b want a=1 b=1", a_rdy, b_rdy);
        else n_pass++;
        qa.delete(); qb.delete(); q_got.delete();
    endtask

    task automatic test_single_pair();
        out_rdy = 1'b1;
        a_val = 1'b1; a_msg = 8'h03;
        b_val = 1'b1; b_msg = 8'h05;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (out_val !== 1'b1 || out_msg !== 16'h0305)
            $display("FAIL single_pair: got val=%b msg=%h want val=1 msg=0305", out_val, out_msg);
        else n_pass++;
        step();
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL single_pair_end: got val=%b want 0", out_val);
        else n_pass++;
    endtask

    task automatic test_skewed();
        out_rdy = 1'b1;
        a_val = 1'b1; a_msg = 8'h11;
        step();
        a_msg = 8'h22;
        step();
        a_val = 1'b0;
        step();
        n_checks++;
        if (a_rdy !== 1'b0) $display("FAIL skew_a_full: got a_rdy=%b want 0", a_rdy);
        else n_pass++;
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL skew_no_out: got val=%b want 0", out_val);
        else n_pass++;
        step();
        b_val = 1'b1; b_msg = 8'hAA;
        step();
        b_msg = 8'hBB;
        step();
        b_val = 1'b0;
        n_checks++;
        if (out_val !== 1'b1 || out_msg !== 16'h11AA)
            $display("FAIL skew_pair0: got val=%b msg=%h want val=1 msg=11aa", out_val, out_msg);
        else n_pass++;
        step();
        n_checks++;
        if (out_val !== 1'b1 || out_msg !== 16'h22BB)
            $display("FAIL skew_pair1: got val=%b msg=%h want val=1 msg=22bb", out_val, out_msg);
        else n_pass++;
        step();
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL skew_end: got val=%b want 0", out_val);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        out_rdy = 1'b1;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            if (cyc < 16) begin
                a_val = 1'b1; a_msg = 8'(cyc);
                b_val = 1'b1; b_msg = 8'(15 - cyc);
                n_checks++;
                if (a_rdy !== 1'b1 || b_rdy !== 1'b1)
                    $display("FAIL b2b_rdy[%0d]: got a=%b b=%b want 1 1", cyc, a_rdy, b_rdy);
                else n_pass++;
            end else begin
                idle_inputs();
            end
            step();
            if (cyc >= 1) begin
                exp = {8'(cyc - 1), 8'(16 - cyc)};
                n_checks++;
                if (out_val !== 1'b1 || out_msg !== exp)
                    $display("FAIL b2b_pair[%0d]: got val=%b msg=%h want val=1 msg=%h",
                             cyc - 1, out_val, out_msg, exp);
                else n_pass++;
            end
        end
        step();
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL b2b_end: got val=%b want 0", out_val);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int na = 0;
        int nb = 0;
        q_got.delete();
        out_rdy = 1'b0;
        a_val = 1'b1; a_msg = 8'(na);
        b_val = 1'b1; b_msg = 8'(nb);
        repeat (8) begin
            if (a_val && a_rdy) na++;
            if (b_val && b_rdy) nb++;
            step();
            a_msg = 8'(na);
            b_msg = 8'(nb);
        end
        n_checks++;
        if (na != 3 || nb != 3) $display("FAIL bp_absorb: got a=%0d b=%0d want 3 3", na, nb);
        else n_pass++;
        n_checks++;
        if (a_rdy !== 1'b0 || b_rdy !== 1'b0)
            $display("FAIL bp_rdy_low: got a=%b b=%b want 0 0", a_rdy, b_rdy);
        else n_pass++;
        n_checks++;
        if (out_val !== 1'b1 || out_msg !== 16'h0000)
            $display("FAIL bp_hold: got val=%b msg=%h want val=1 msg=0000", out_val, out_msg);
        else n_pass++;
        out_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_val && a_rdy) na++;
            if (b_val && b_rdy) nb++;
            step();
            if (c == 0) begin
                n_checks++;
                if (a_rdy !== 1'b1 || b_rdy !== 1'b1)
                    $display("FAIL bp_rdy_back: got a=%b b=%b want 1 1", a_rdy, b_rdy);
                else n_pass++;
            end
            a_val = (na < 6); a_msg = 8'(na);
            b_val = (nb < 6); b_msg = 8'(nb);
        end
        idle_inputs();
        repeat (4) step();
        n_checks++;
        if (q_got.size() != 6) $display("FAIL bp_count: got %0d want 6", q_got.size());
        else n_pass++;
        for (int k = 0; k < q_got.size(); k++) begin
            n_checks++;
            if (q_got[k] !== {8'(k), 8'(k)})
                $display("FAIL bp_order[%0d]: got %h want %h", k, q_got[k], {8'(k), 8'(k)});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        a_val = 1'b1; a_msg = 8'h01;
        b_val = 1'b1; b_msg = 8'h02;
        step();
        a_msg = 8'h03; b_msg = 8'h04;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (out_val !== 1'b1) $display("FAIL mid_pre: got val=%b want 1", out_val);
        else n_pass++;
        // Reset with new handshakes in flight and the output draining
        reset = 1'b0;
        out_rdy = 1'b1;
        a_val = 1'b1; a_msg = 8'h05;
        b_val = 1'b1; b_msg = 8'h06;
        step();
        reset = 1'b1;
        idle_inputs();
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL mid_out_val: got val=%b want 0", out_val);
        else n_pass++;
        n_checks++;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1)
            $display("FAIL mid_rdy: got a=%b b=%b want 1 1", a_rdy, b_rdy);
        else n_pass++;
        a_val = 1'b1; a_msg = 8'h07;
        b_val = 1'b1; b_msg = 8'h09;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (out_val !== 1'b1 || out_msg !== 16'h0709)
            $display("FAIL mid_next: got val=%b msg=%h want val=1 msg=0709", out_val, out_msg);
        else n_pass++;
        step();
        n_checks++;
        if (out_val !== 1'b0) $display("FAIL mid_stale: got val=%b msg=%h want val=0", out_val, out_msg);
        else n_pass++;
    endtask

    task automatic test_random();
        logic acc_a;
        logic acc_b;
        int   n_exp;
        do_reset();
        a_val = 1'b0; b_val = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            acc_a = a_val && a_rdy;
            acc_b = b_val && b_rdy;
            step();
            if (!a_val || acc_a) begin
                a_val = 1'($urandom_range(0, 1));
                a_msg = 8'($urandom);
            end
            if (!b_val || acc_b) begin
                b_val = 1'($urandom_range(0, 1));
                b_msg = 8'($urandom);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
        end
        // Let in-flight operands drain, then stop driving
        acc_a = a_val && a_rdy;
        acc_b = b_val && b_rdy;
        step();
        if (!(a_val && !acc_a)) a_val = 1'b0;
        if (!(b_val && !acc_b)) b_val = 1'b0;
        out_rdy = 1'b1;
        repeat (10) begin
            acc_a = a_val && a_rdy;
            acc_b = b_val && b_rdy;
            step();
            if (acc_a) a_val = 1'b0;
            if (acc_b) b_val = 1'b0;
        end
        idle_inputs();
        repeat (4) step();
        n_exp = (qa.size() < qb.size()) ? qa.size() : qb.size();
        n_checks++;
        if (q_got.size() != n_exp) $display("FAIL rnd_count: got %0d want %0d", q_got.size(), n_exp);
        else n_pass++;
        for (int k = 0; k < q_got.size() && k < n_exp; k++) begin
            n_checks++;
            if (q_got[k] !== {qa[k], qb[k]})
                $display("FAIL rnd_pair[%0d]: got %h want %h", k, q_got[k], {qa[k], qb[k]});
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0;
        out_rdy = 1'b0;
        idle_inputs();
        test_reset();
        test_single_pair();
        test_skewed();
        test_back_to_back();
        do_reset();
        test_backpressure();
        do_reset();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_operand_join.md
# mac_operand_join

Upstream operand-pairing stage for the multiply-accumulate datapath. Two independent val/rdy operand streams, A and B, are each buffered in a small queue. Matching heads are joined in order into one registered `{a, b}` message. That message drives the MAC request interface, where `out_msg` connects to the MAC's `2*p_width` request message. Full throughput is one pair per cycle, and no combinational path runs from `out_rdy` to `a_rdy` or `b_rdy`.

## Interface

Parameters:
- `p_width`, default 8: operand width; the output is `2*p_width`.
- `p_depth`, default 2: entries per input queue; must be a power of two and ≥2.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; `0` = reset, sampled at the rising edge of `clk`.
- `a_val`  in  1  operand A valid.
- `a_rdy`  out  1  operand A queue can accept.
- `a_msg`  in  `p_width`  operand A.
- `b_val`  in  1  operand B valid.
- `b_rdy`  out  1  operand B queue can accept.
- `b_msg`  in  `p_width`  operand B.
- `out_val`  out  1  joined pair valid.
- `out_rdy`  in  1  downstream (MAC) ready.
- `out_msg`  out  `2*p_width`  `{a, b}`: A in bits `[2*p_width-1:p_width]`, B in bits `[p_width-1:0]`.

## Operation

- A transfer occurs when `val && rdy` at a rising edge. Senders must hold `val` and `msg` until the transfer.
- Each input has its own FIFO queue of `p_depth` entries with head/tail pointers and a count.
  - `x_rdy = (count_x != p_depth)`; this comes from a register only.
  - There is no enqueue on a full queue, even when a dequeue happens in the same cycle.
  - Pointers wrap modulo `p_depth` with no skipped entries.
- Output stage: one register holding `out_val_q` and `out_msg_q`.
  - `load = !empty_a && !empty_b && (!out_val_q || out_rdy)`.
  - On `load`, both queue heads pop in the same cycle and `out_msg_q <= {head_a, head_b}`.
  - If `out_val_q && out_rdy && !load`, then `out_val_q <= 0`.
  - If `out_val_q && !out_rdy`, the register holds and neither queue pops.
- Pairing is strictly positional: the k-th accepted A always pairs with the k-th accepted B. A stream running ahead of the other only fills its own queue.
- Simultaneous enqueue and dequeue on a non-full queue leaves the count unchanged, and both pointers advance.
- No arithmetic is performed on operands. Messages pass bit-exact.
- There is no error or overflow condition; backpressure is the only flow control.

## Timing

Reset values (while `reset==0` at an edge):
- All queue counts = 0 and all pointers = 0.
- `out_val = 0`.
- `a_rdy = b_rdy = 1` from the cycle after reset deasserts.
- Queue storage and `out_msg` are don't-care, but a bench may expect `out_msg = 0`.

Reset mid-operation:
- Reset discards all queued and registered data regardless of handshakes in flight.
- `out_val = 0` in the cycle after reset is sampled low.

Latency and throughput:
- If A and B are accepted in cycle t with both queues previously empty, `out_val = 1` in cycle t+1.
- In general, a pair appears one cycle after its later operand is accepted.
- Throughput is one pair per cycle with `out_rdy` held high and both inputs streaming.
- With `p_depth=2`, the counts never exceed 1 in steady streaming.

Backpressure:
- With `out_rdy = 0` indefinitely, the block absorbs exactly `p_depth` A operands plus 1 pair in the output register; the same holds for B.
- After that, `a_rdy` and `b_rdy` deassert.
- The first cycle `out_rdy = 1` drains the register and reloads it in the same cycle. `x_rdy` reasserts in the following cycle.

## Structure

- Package `mac_pkg` (shared with the MAC stage): `localparam` default widths, plus `typedef` of the joined-pair struct `{a, b}`. This keeps the upstream and downstream half ordering defined in one place.
- One sub-module, `mac_operand_queue`.
  - Parameters: `p_width`, `p_depth`.
  - Ports: `clk`, `reset`, `enq_val`, `enq_rdy`, `enq_msg`, `deq_val`, `deq_rdy`, `deq_msg`.
  - `deq_val = !empty`; `deq_msg = storage[head]`.
- The top level instantiates the queue twice and adds the join logic and output register.

## Test plan

All cases use `p_width=8`, `p_depth=2`.

1. **Single pair.** Stimulus: A=`0x03` and B=`0x05` in cycle 0, `out_rdy=1`. Required: `out_val=1`, `out_msg=0x0305` in cycle 1, then `out_val=0`.
2. **Skewed streams.** Stimulus: A sends `0x11`, `0x22` in cycles 0–1; B sends `0xAA`, `0xBB` in cycles 4–5. Required: `a_rdy=0` in cycle 2 (queue full); outputs `0x11AA` in cycle 5 and `0x22BB` in cycle 6.
3. **Back-to-back.** Stimulus: 16 pairs with A=i and B=15−i, `out_rdy=1`. Required: 16 consecutive `out_val` cycles starting at cycle 1, each `out_msg = {i, 15-i}`, in order.
4. **Backpressure.** Stimulus: `out_rdy=0` while streaming both inputs. Required: exactly 3 A and 3 B accepted, then `a_rdy=b_rdy=0`, with `out_msg=0x0000` held for pair 0. After `out_rdy=1`, all pairs emerge in order with no loss or duplication.
5. **Reset mid-operation.** Stimulus: queues at count 1 and `out_val=1`, then `reset=0` for 1 cycle. Required: `out_val=0` and `a_rdy=b_rdy=1` afterwards; the next pair A=`0x07`, B=`0x09` yields `0x0709`, with no stale data.
6. **Random test.** Stimulus: random `val`/`rdy` toggling for 1000 cycles, checked against a scoreboard. Required: every pair = `{k-th A, k-th B}`.
